cs_decoder_seq: RTL and testbench

Parametrised, registered multi-channel chip-select decoder for the arcade memory/IO map. Each channel decodes an ABITS-bit address into 2^ABITS active-low selects behind an active-low enable. It adds a per-channel address latch and a per-channel one-shot pulse mode for strobe-style selects (latches, watchdog, sound triggers). With CHANNELS=2, ABITS=2 and pulse held low, it behaves as a dual 2-to-4 decoder delayed by one clock.

---
 rtl/cs_decoder_seq.sv | 107 ++++++++++
 tb/tb_cs_decoder_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cs_decoder_seq.sv
// Registered multi-channel chip-select decoder with per-channel address latch
// and one-shot pulse mode for strobe-style selects.
module cs_decoder_seq #(
    parameter int CHANNELS  = 2,
    parameter int ABITS     = 2,
    parameter int PULSE_LEN = 4,
    localparam int OUTS     = 1 << ABITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en_n,
    input  logic [CHANNELS-1:0]       le,
    input  logic [CHANNELS*ABITS-1:0] a,
    input  logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS*OUTS-1:0]  sel_n,
    output logic [CHANNELS-1:0]       active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_t            state_q, state_d;
            logic [ABITS-1:0]  addr_q, addr_d;
            logic [ABITS-1:0]  fired_q, fired_d;
            logic [7:0]        cnt_q, cnt_d;
            logic [OUTS-1:0]   sel_q, sel_d;
            logic              active_q, active_d;
            logic [ABITS-1:0]  eff;
            logic [OUTS-1:0]   dec;
            logic              trigger;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q  <= IDLE;
                    addr_q   <= '0;
                    fired_q  <= '0;
                    cnt_q    <= '0;
                    sel_q    <= '1;
                    active_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    addr_q   <= addr_d;
                    fired_q  <= fired_d;
                    cnt_q    <= cnt_d;
                    sel_q    <= sel_d;
                    active_q <= active_d;
                end
            end

            always_comb begin
                state_d = state_q;
                fired_d = fired_q;
                cnt_d   = cnt_q;
                sel_d   = sel_q;
                eff     = le[gi] ? a[gi*ABITS +: ABITS] : addr_q;
                addr_d  = eff;
                dec     = '1;
                dec[eff] = 1'b0;
                // A pulse fires from IDLE, or when the effective address moves
                // away from the one that last fired (retrigger, no gap cycle).
                trigger = !en_n[gi] && ((state_q == IDLE) || (eff != fired_q));

                if (!pulse[gi]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = en_n[gi] ? '1 : dec;
                end else if (en_n[gi]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = '1;
                end else if (trigger) begin
                    state_d = FIRE;
                    fired_d = eff;
                    cnt_d   = CNT_LOAD;
                    sel_d   = dec;
                end else begin
                    case (state_q)
                        FIRE: begin
                            if (cnt_q != 8'd0) begin
                                cnt_d = cnt_q - 8'd1;
                            end else begin
                                state_d = HOLD;
                                sel_d   = '1;
                            end
                        end
                        HOLD:    sel_d = '1;
                        default: sel_d = '1;
                    endcase
                end

                active_d = ~&sel_d;
            end

            assign sel_n[gi*OUTS +: OUTS] = sel_q;
            assign active[gi]             = active_q;
        end
    endgenerate

endmodule

// File: tb/tb_cs_decoder_seq.sv
// Directed self-checking bench for cs_decoder_seq: a default dual 2-to-4
// instance plus a single-channel PULSE_LEN=1 instance for strobe timing.
module tb_cs_decoder_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en_n, le, pulse;
    logic [3:0] a;
    logic [7:0] sel_n;
    logic [1:0] active;

    logic [0:0] en_n1, le1, pulse1;
    logic [1:0] a1;
    logic [3:0] sel_n1;
    logic [0:0] active1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cs_decoder_seq #(.CHANNELS(2), .ABITS(2), .PULSE_LEN(4)) dut (
        .clk(clk), .reset(reset), .en_n(en_n), .le(le), .a(a),
        .pulse(pulse), .sel_n(sel_n), .active(active)
    );

    cs_decoder_seq #(.CHANNELS(1), .ABITS(2), .PULSE_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .en_n(en_n1), .le(le1), .a(a1),
        .pulse(pulse1), .sel_n(sel_n1), .active(active1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks both selects and the active flags; active is derived from the
    // expected selects: high when any select in the channel is low.
    task automatic chk(input string tag, input logic [7:0] exp_sel);
        logic [1:0] exp_act;
        exp_act = {~&exp_sel[7:4], ~&exp_sel[3:0]};
        checks++;
        assert (sel_n === exp_sel) else begin
            errors++;
            $error("FAIL %s sel_n observed=%b expected=%b", tag, sel_n, exp_sel);
        end
        checks++;
        assert (active === exp_act) else begin
            errors++;
            $error("FAIL %s active observed=%b expected=%b", tag, active, exp_act);
        end
        $display("t=%0t %s sel_n=%b active=%b", $time, tag, sel_n, active);
    endtask

    task automatic chk1(input string tag, input logic [3:0] exp_sel);
        checks++;
        assert (sel_n1 === exp_sel && active1 === ~&exp_sel) else begin
            errors++;
            $error("FAIL %s sel_n1/active1 observed=%b/%b expected=%b/%b",
                   tag, sel_n1, active1, exp_sel, ~&exp_sel);
        end
        $display("t=%0t %s sel_n1=%b active1=%b", $time, tag, sel_n1, active1);
    endtask

    logic [7:0] lvl_exp [4] = '{8'h7E, 8'hBD, 8'hDB, 8'hE7};

    initial begin
        reset = 1'b1; en_n = 2'b00; pulse = 2'b00; le = 2'b11; a = 4'b1111;
        en_n1 = 1'b1; pulse1 = 1'b1; le1 = 1'b1; a1 = 2'd2;

        // Reset held three cycles despite enabled level decode
        for (int i = 0; i < 3; i++) begin
            step(); chk("reset", 8'hFF);
        end
        chk1("reset_s1", 4'hF);
        reset = 1'b0;
        step(); chk("post_reset", 8'h77);

        // Level sweep: ch0 counts up, ch1 counts down
        for (int i = 0; i < 4; i++) begin
            a = {2'(3 - i), 2'(i)};
            step(); chk("level", lvl_exp[i]);
        end
        en_n = 2'b11;
        step(); chk("level_dis", 8'hFF);

        // Latch hold
        en_n = 2'b00; a = {2'd0, 2'd1};
        step(); chk("latch_load", 8'hED);
        le = 2'b00; a = 4'b1111;
        step(); chk("latch_hold", 8'hED);
        step(); chk("latch_hold2", 8'hED);
        le = 2'b11;
        step(); chk("latch_reload", 8'h77);

        // Pulse width on ch0 (ch1 stays level at address 0)
        en_n = 2'b01; pulse = 2'b01; a = {2'd0, 2'd2};
        step(); chk("pulse_arm", 8'hEF);
        en_n = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(); chk("pulse_low", 8'hEB);
        end
        for (int i = 0; i < 20; i++) begin
            step(); chk("pulse_hold", 8'hEF);
        end

        // Retrigger after two pulse clocks
        en_n = 2'b01;
        step(); chk("rt_idle", 8'hEF);
        en_n = 2'b00;
        step(); chk("rt_fire1", 8'hEB);
        step(); chk("rt_fire2", 8'hEB);
        a = {2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(); chk("rt_new", 8'hEE);
        end
        step(); chk("rt_end", 8'hEF);

        // Disable mid-pulse, then re-enable at the same address
        a = {2'd0, 2'd2};
        step(); chk("dis_fire", 8'hEB);
        step(); chk("dis_fire2", 8'hEB);
        en_n = 2'b01;
        step(); chk("dis_off", 8'hEF);
        en_n = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(); chk("reen_low", 8'hEB);
        end
        step(); chk("reen_end", 8'hEF);

        // Address change with le=0 in HOLD is ignored
        le = 2'b10; a = {2'd0, 2'd1};
        step(); chk("le0_ignore", 8'hEF);
        step(); chk("le0_ignore2", 8'hEF);
        le = 2'b11;

        // Reset asserted mid-pulse, then a fresh pulse after release
        a = {2'd0, 2'd3};
        step(); chk("rst_fire", 8'hE7);
        reset = 1'b1;
        step(); chk("rst_mid", 8'hFF);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("rst_new", 8'hE7);
        end
        step(); chk("rst_end", 8'hEF);

        // Mode change: level then back to pulse fires once
        pulse = 2'b00;
        step(); chk("mode_lvl", 8'hE7);
        step(); chk("mode_lvl2", 8'hE7);
        pulse = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step(); chk("mode_pulse", 8'hE7);
        end
        step(); chk("mode_end", 8'hEF);

        // PULSE_LEN=1 single-cycle strobe
        en_n1 = 1'b0;
        step(); chk1("strobe", 4'b1011);
        step(); chk1("strobe_end", 4'hF);
        step(); chk1("strobe_hold", 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
